// File: rtl/io_console.sv
// io_console -- text console on the CPU's external I/O bus.
//
// Takes one-cycle iow writes aimed at the console, queues the characters in
// a small FIFO (the CPU never waits) and renders them into a registered
// single-port text-buffer RAM. Handles the cursor, CR/LF/BS/FF, line wrap,
// scroll-up and clear-screen.
//
// Optional feature: define CONSOLE_TAB_EN to make 0x09 advance the cursor
// to the next multiple of 8 (wrapping to a new line past the last column).
// Without it, 0x09 is ignored like any other non-printable code.
//
// Ports:
//   CLOCK, RESET      clock, synchronous active-high reset
//   ioad/iowdt/iow    I/O write address, data, one-cycle strobe
//   rdad/ior/iordt    I/O read address, strobe, combinational read data
//   tb_addr/tb_wdata  text-buffer address and write data
//   tb_we             text-buffer write enable
//   tb_rdata          text-buffer read data, valid 1 cycle after tb_addr
//   busy              FSM not idle or FIFO not empty
//
// Registers (base CHAR_ADDR):
//   +0 W  push character
//   +1 R  {13'd0, ovf, fifo_full, busy}; an ior here clears ovf
//   +1 W  bit 1 queues a clear-screen (FF)
//   +2 RW cursor {3'd0, y[4:0], 2'd0, x[5:0]}; writes only when fully idle
module io_console #(
  parameter int         COLS       = 40,
  parameter int         ROWS       = 25,
  parameter int         TB_AW      = 11,
  parameter logic [7:0] CHAR_ADDR  = 8'h12,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic [7:0]       ioad,
  input  logic [15:0]      iowdt,
  input  logic             iow,
  input  logic [7:0]       rdad,
  input  logic             ior,
  output logic [15:0]      iordt,
  output logic [TB_AW-1:0] tb_addr,
  output logic [7:0]       tb_wdata,
  output logic             tb_we,
  input  logic [7:0]       tb_rdata,
  output logic             busy
);

  localparam int PW = $clog2(FIFO_DEPTH);

  localparam logic [7:0]       STAT_REG   = CHAR_ADDR + 8'd1;
  localparam logic [7:0]       CUR_REG    = CHAR_ADDR + 8'd2;
  localparam logic [5:0]       X_MAX      = 6'(COLS - 1);
  localparam logic [4:0]       Y_MAX      = 5'(ROWS - 1);
  localparam logic [TB_AW-1:0] A_ONE      = TB_AW'(1);
  localparam logic [TB_AW-1:0] A_COLS     = TB_AW'(COLS);
  localparam logic [TB_AW-1:0] A_SCR_LAST = TB_AW'(COLS * (ROWS - 1) - 1);
  localparam logic [TB_AW-1:0] A_BLANK0   = TB_AW'(COLS * (ROWS - 1));
  localparam logic [TB_AW-1:0] A_LAST     = TB_AW'(COLS * ROWS - 1);
  localparam logic [PW:0]      CNT_FULL   = (PW + 1)'(FIFO_DEPTH);

  // SCROLL_PRE exists only so a printable that wraps off the last row can
  // finish its own write before the scroll starts reading.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCROLL_PRE,
    ST_SCROLL_RD,
    ST_SCROLL_WR,
    ST_SCROLL_BLANK,
    ST_CLEAR
  } state_e;

  state_e           state_q, state_d;
  logic [5:0]       x_q, x_d;
  logic [4:0]       y_q, y_d;
  logic [TB_AW-1:0] a_q, a_d;        // cell index for scroll/clear sweeps
  logic [TB_AW-1:0] addr_q, addr_d;
  logic             we_q, we_d;
  logic [7:0]       wdata_q, wdata_d;
  logic             copy_q, copy_d;  // scroll copy cycle: write RAM read data
  logic             ovf_q, ovf_d;

  logic [7:0]       fifo_q [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]      cnt_q, cnt_d;

  logic             fifo_empty, fifo_full;
  logic             pop, push_req, push_ok, cur_wr;
  logic             do_lf, wr_pend;
  logic [7:0]       ch, push_data;
  logic [TB_AW-1:0] cur_addr;
  logic             unused_ok;

`ifdef CONSOLE_TAB_EN
  localparam logic [6:0] TAB_LIM = 7'(COLS);
  logic [6:0] tab_x;
`endif

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == CNT_FULL);
  assign busy       = (state_q != ST_IDLE) || !fifo_empty;
  assign cur_addr   = TB_AW'(y_q) * A_COLS + TB_AW'(x_q);
  assign unused_ok  = ^{iowdt[15:13], iowdt[7:6]};

  assign tb_addr  = addr_q;
  assign tb_we    = we_q;
  assign tb_wdata = copy_q ? tb_rdata : wdata_q;

  always_comb begin
    iordt = '0;
    if (rdad == STAT_REG)     iordt = {13'd0, ovf_q, fifo_full, busy};
    else if (rdad == CUR_REG) iordt = {3'd0, y_q, 2'd0, x_q};
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    a_d     = a_q;
    addr_d  = addr_q;
    we_d    = 1'b0;
    wdata_d = wdata_q;
    copy_d  = 1'b0;
    pop     = 1'b0;
    do_lf   = 1'b0;
    wr_pend = 1'b0;
    ch      = fifo_q[rd_ptr_q];
`ifdef CONSOLE_TAB_EN
    tab_x   = '0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (ch >= 8'h20 && ch <= 8'h7E) begin
            addr_d  = cur_addr;
            we_d    = 1'b1;
            wdata_d = ch;
            wr_pend = 1'b1;
            if (x_q == X_MAX) begin
              x_d   = '0;
              do_lf = 1'b1;
            end else begin
              x_d = x_q + 6'd1;
            end
          end else begin
            case (ch)
              8'h0D: x_d = '0;
              8'h0A: do_lf = 1'b1;
              8'h08: begin
                // No wrap back to the previous row at column 0.
                if (x_q != '0) begin
                  x_d     = x_q - 6'd1;
                  addr_d  = cur_addr - A_ONE;
                  we_d    = 1'b1;
                  wdata_d = 8'h20;
                end
              end
              8'h0C: begin
                state_d = ST_CLEAR;
                a_d     = '0;
                addr_d  = '0;
                we_d    = 1'b1;
                wdata_d = 8'h20;
              end
`ifdef CONSOLE_TAB_EN
              8'h09: begin
                // 7-bit so a tab from the top octet cannot wrap to 0.
                tab_x = {1'b0, x_q[5:3], 3'b000} + 7'd8;
                if (tab_x >= TAB_LIM) begin
                  x_d   = '0;
                  do_lf = 1'b1;
                end else begin
                  x_d = tab_x[5:0];
                end
              end
`endif
              default: ;
            endcase
          end

          if (do_lf) begin
            if (y_q != Y_MAX) begin
              y_d = y_q + 5'd1;
            end else if (wr_pend) begin
              state_d = ST_SCROLL_PRE;
            end else begin
              state_d = ST_SCROLL_RD;
              a_d     = '0;
              addr_d  = A_COLS;
            end
          end
        end
      end

      ST_SCROLL_PRE: begin
        state_d = ST_SCROLL_RD;
        a_d     = '0;
        addr_d  = A_COLS;
      end

      // Read cell a+COLS this cycle; the registered RAM returns it next
      // cycle, when it is written straight through to cell a.
      ST_SCROLL_RD: begin
        state_d = ST_SCROLL_WR;
        addr_d  = a_q;
        we_d    = 1'b1;
        copy_d  = 1'b1;
      end

      ST_SCROLL_WR: begin
        if (a_q == A_SCR_LAST) begin
          state_d = ST_SCROLL_BLANK;
          a_d     = A_BLANK0;
          addr_d  = A_BLANK0;
          we_d    = 1'b1;
          wdata_d = 8'h20;
        end else begin
          state_d = ST_SCROLL_RD;
          a_d     = a_q + A_ONE;
          addr_d  = a_q + A_ONE + A_COLS;
        end
      end

      ST_SCROLL_BLANK: begin
        if (a_q == A_LAST) begin
          state_d = ST_IDLE;
          y_d     = Y_MAX;
        end else begin
          a_d    = a_q + A_ONE;
          addr_d = a_q + A_ONE;
          we_d   = 1'b1;
        end
      end

      ST_CLEAR: begin
        if (a_q == A_LAST) begin
          state_d = ST_IDLE;
          x_d     = '0;
          y_d     = '0;
        end else begin
          a_d    = a_q + A_ONE;
          addr_d = a_q + A_ONE;
          we_d   = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Cursor writes only land when nothing is pending, so they can never
    // race a character that is still in flight.
    cur_wr = iow && (ioad == CUR_REG) && (state_q == ST_IDLE) && fifo_empty;
    if (cur_wr) begin
      x_d = (iowdt[5:0]  > X_MAX) ? X_MAX : iowdt[5:0];
      y_d = (iowdt[12:8] > Y_MAX) ? Y_MAX : iowdt[12:8];
    end

    push_req  = iow && ((ioad == CHAR_ADDR) || ((ioad == STAT_REG) && iowdt[1]));
    push_data = (ioad == CHAR_ADDR) ? iowdt[7:0] : 8'h0C;
    // A pop in the same cycle frees a slot even when full.
    push_ok   = push_req && (!fifo_full || pop);
    wr_ptr_d  = wr_ptr_q + PW'(push_ok);
    rd_ptr_d  = rd_ptr_q + PW'(pop);
    cnt_d     = cnt_q + (PW + 1)'(push_ok) - (PW + 1)'(pop);

    ovf_d = ovf_q;
    if (ior && (rdad == STAT_REG)) ovf_d = 1'b0;
    if (push_req && !push_ok)      ovf_d = 1'b1;
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      a_q      <= '0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= 8'h20;
      copy_q   <= 1'b0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      a_q      <= a_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      copy_q   <= copy_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage only; occupancy is tracked by the reset pointers.
  always_ff @(posedge CLOCK) begin
    if (push_ok) fifo_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: tb/tb_io_console.sv
// Directed bench for io_console: behavioural registered text-buffer RAM,
// write log, hand-computed expectations.
module tb_io_console;
  localparam int TB_AW = 11;

  logic             CLOCK = 1'b0;
  logic             RESET = 1'b1;
  logic [7:0]       ioad  = '0;
  logic [15:0]      iowdt = '0;
  logic             iow   = 1'b0;
  logic [7:0]       rdad  = '0;
  logic             ior   = 1'b0;
  logic [15:0]      iordt;
  logic [TB_AW-1:0] tb_addr;
  logic [7:0]       tb_wdata;
  logic             tb_we;
  logic [7:0]       tb_rdata;
  logic             busy;

  logic [7:0]  ram  [0:2047];
  logic [7:0]  snap [0:2047];
  logic        ram_init = 1'b0;
  logic [18:0] wr_log [$];
  int          n_tests = 0;
  int          n_fail  = 0;

  io_console dut (
    .CLOCK(CLOCK), .RESET(RESET),
    .ioad(ioad), .iowdt(iowdt), .iow(iow),
    .rdad(rdad), .ior(ior), .iordt(iordt),
    .tb_addr(tb_addr), .tb_wdata(tb_wdata), .tb_we(tb_we),
    .tb_rdata(tb_rdata), .busy(busy)
  );

  always #5 CLOCK = ~CLOCK;

  // Registered single-port RAM; preloaded with a pattern on the first edge.
  always @(posedge CLOCK) begin
    tb_rdata <= ram[tb_addr];
    if (!ram_init) begin
      for (int i = 0; i < 2048; i++) ram[i] <= 8'(i * 3 + 1);
      ram_init <= 1'b1;
    end else if (tb_we) begin
      ram[tb_addr] <= tb_wdata;
      wr_log.push_back({tb_addr, tb_wdata});
    end
  end

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input logic [7:0] a, input logic [15:0] exp);
    rdad = a;
    #1;
    chk(tag, 32'(iordt), 32'(exp));
  endtask

  task automatic io_wr(input logic [7:0] a, input logic [15:0] d);
    ioad  = a;
    iowdt = d;
    iow   = 1'b1;
    tick();
    iow   = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max);
    for (int k = 0; k < max && busy; k++) tick();
    chk(tag, 32'(busy), 32'd0);
    repeat (2) tick();
  endtask

  function automatic logic [18:0] log_at(input int i);
    if (i < wr_log.size()) return wr_log[i];
    return 19'h7FFFF;
  endfunction

  initial begin
    int cnt;
    int bad;
    logic found;

    // Reset state
    repeat (3) tick();
    chk("rst_we",    32'(tb_we),    32'd0);
    chk("rst_addr",  32'(tb_addr),  32'd0);
    chk("rst_wdata", 32'(tb_wdata), 32'h20);
    chk("rst_busy",  32'(busy),     32'd0);
    chk_reg("rst_stat", 8'h13, 16'h0000);
    chk_reg("rst_cur",  8'h14, 16'h0000);
    chk_reg("rd_other", 8'h15, 16'h0000);
    RESET = 1'b0;
    tick();

    // 'A','B' back to back
    wr_log.delete();
    io_wr(8'h12, 16'h0041);
    io_wr(8'h12, 16'h0042);
    wait_idle("ab_idle", 20);
    chk("ab_nwr", 32'(wr_log.size()), 32'd2);
    chk("ab_w0",  32'(log_at(0)), {13'd0, 11'd0, 8'h41});
    chk("ab_w1",  32'(log_at(1)), {13'd0, 11'd1, 8'h42});
    chk_reg("ab_cur", 8'h14, 16'h0002);

    // Backspace, and backspace at column 0
    io_wr(8'h14, 16'h0205);
    chk_reg("bs_set", 8'h14, 16'h0205);
    wr_log.delete();
    io_wr(8'h12, 16'h0008);
    wait_idle("bs_idle", 20);
    chk("bs_nwr", 32'(wr_log.size()), 32'd1);
    chk("bs_w",   32'(log_at(0)), {13'd0, 11'd84, 8'h20});
    chk_reg("bs_cur", 8'h14, 16'h0204);
    io_wr(8'h14, 16'h0200);
    wr_log.delete();
    io_wr(8'h12, 16'h0008);
    wait_idle("bs0_idle", 20);
    chk("bs0_nwr", 32'(wr_log.size()), 32'd0);
    chk_reg("bs0_cur", 8'h14, 16'h0200);

    // Cursor clamp
    io_wr(8'h14, 16'h1F3F);
    chk_reg("clamp_cur", 8'h14, 16'h1827);

    // Status write without bit 1 must not queue anything
    io_wr(8'h13, 16'h0001);
    chk("ff_nobit", 32'(busy), 32'd0);

    // 40 printables on the last row: wrap and scroll
    io_wr(8'h14, 16'h1800);
    for (int i = 0; i < 40; i++) begin
      io_wr(8'h12, 16'(8'h41 + 8'(i % 26)));
      if (i < 39) tick();
    end
    found = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      if (tb_we && tb_addr == 11'd999) found = 1'b1;
      else tick();
    end
    chk("scr_hit999", 32'(found), 32'd1);
    chk("scr_w999",   32'(tb_wdata), 32'h4E);
    tick();
    for (int i = 0; i < 2048; i++) snap[i] = ram[i];
    cnt = 0;
    while (busy && cnt < 3000) begin
      cnt++;
      tick();
    end
    chk("scr_cycles", 32'(cnt), 32'd1960);
    repeat (2) tick();
    bad = 0;
    for (int a = 0; a < 960; a++) if (ram[a] !== snap[a + 40]) bad++;
    chk("scr_shift", 32'(bad), 32'd0);
    chk("scr_r0c0",  32'(ram[0]),   32'(snap[40]));
    chk("scr_r23c0", 32'(ram[920]), 32'h41);
    chk("scr_r23c39", 32'(ram[959]), 32'h4E);
    bad = 0;
    for (int a = 960; a < 1000; a++) if (ram[a] !== 8'h20) bad++;
    chk("scr_blank", 32'(bad), 32'd0);
    chk_reg("scr_cur", 8'h14, 16'h1800);

    // Overflow: LF scrolls, six chars back to back, four fit
    io_wr(8'h12, 16'h000A);
    for (int i = 0; i < 6; i++) io_wr(8'h12, 16'(8'h61 + 8'(i)));
    chk_reg("ovf_stat", 8'h13, 16'h0007);
    rdad = 8'h13;
    ior  = 1'b1;
    tick();
    ior  = 1'b0;
    chk_reg("ovf_clr", 8'h13, 16'h0003);
    wait_idle("ovf_idle", 3000);
    chk("ovf_c0", 32'(ram[960]), 32'h61);
    chk("ovf_c1", 32'(ram[961]), 32'h62);
    chk("ovf_c3", 32'(ram[963]), 32'h64);
    chk("ovf_c4", 32'(ram[964]), 32'h20);
    chk_reg("ovf_cur", 8'h14, 16'h1804);

    // Full clear via FF
    wr_log.delete();
    io_wr(8'h13, 16'h0002);
    wait_idle("clr_idle", 1200);
    chk("clr_nwr", 32'(wr_log.size()), 32'd1000);
    bad = 0;
    for (int i = 0; i < 1000; i++) if (log_at(i) !== {11'(i), 8'h20}) bad++;
    chk("clr_data", 32'(bad), 32'd0);
    chk_reg("clr_cur", 8'h14, 16'h0000);

    // Reset during clear, with a char still queued
    io_wr(8'h14, 16'h0307);
    wr_log.delete();
    io_wr(8'h13, 16'h0002);
    io_wr(8'h12, 16'h005A);
    found = 1'b0;
    for (int k = 0; k < 400 && !found; k++) begin
      if (tb_we && tb_addr == 11'd299) found = 1'b1;
      else tick();
    end
    chk("rc_hit300", 32'(found), 32'd1);
    RESET = 1'b1;
    tick();
    chk("rc_we",    32'(tb_we),    32'd0);
    chk("rc_addr",  32'(tb_addr),  32'd0);
    chk("rc_wdata", 32'(tb_wdata), 32'h20);
    chk("rc_busy",  32'(busy),     32'd0);
    chk_reg("rc_stat", 8'h13, 16'h0000);
    chk_reg("rc_cur",  8'h14, 16'h0000);
    RESET = 1'b0;
    repeat (3) tick();
    chk("rc_nwr", 32'(wr_log.size()), 32'd300);

    // TAB
    io_wr(8'h14, 16'h0003);
    wr_log.delete();
    io_wr(8'h12, 16'h0009);
    wait_idle("tab_idle", 20);
    chk("tab_nwr", 32'(wr_log.size()), 32'd0);
`ifdef CONSOLE_TAB_EN
    chk_reg("tab_x3", 8'h14, 16'h0008);
    io_wr(8'h14, 16'h0025);
    io_wr(8'h12, 16'h0009);
    wait_idle("tab2_idle", 20);
    chk_reg("tab_x37", 8'h14, 16'h0100);
`else
    chk_reg("tab_ign", 8'h14, 16'h0003);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/io_console.md
Name: io_console

Overview:
- Downstream I/O peripheral on the CPU's external I/O bus. Consumes the one-cycle `iow` write pulses addressed to the console and renders each character into the text-display buffer RAM.
- Handles the cursor, control characters, line wrap, scroll-up and clear-screen.
- Buffers bursts of CPU writes in a small FIFO, because the CPU never waits.

Parameters:
- COLS, 40, characters per row.
- ROWS, 25, rows on screen.
- TB_AW, 11, text-buffer address width; COLS*ROWS must be ≤ 2^TB_AW.
- CHAR_ADDR, 8'h12, base I/O address. Registers sit at base +0, +1 and +2.
- FIFO_DEPTH, 4, character FIFO entries; must be a power of 2.

Ports:
- CLOCK  in  1  system clock.
- RESET  in  1  synchronous, active-high reset.
- ioad  in  8  I/O write address; valid only while `iow` is high.
- iowdt  in  16  I/O write data.
- iow  in  1  one-cycle write strobe.
- rdad  in  8  I/O read address.
- ior  in  1  one-cycle read strobe.
- iordt  out  16  read data; a combinational decode of `rdad`.
- tb_addr  out  TB_AW  text-buffer address.
- tb_wdata  out  8  text-buffer write data.
- tb_we  out  1  text-buffer write enable.
- tb_rdata  in  8  text-buffer read data; registered RAM, valid 1 cycle after `tb_addr`.
- busy  out  1  high while the FSM is not IDLE or the FIFO is not empty.

Behaviour:
- Reset values:
  - `tb_we`=0, `tb_addr`=0, `tb_wdata`=8'h20.
  - Cursor x=y=0, FIFO empty, overflow flag `ovf`=0, FSM=IDLE, `busy`=0.
  - Reset asserted mid-scroll or mid-clear aborts at once. Buffer contents are left as they are.
- Register map:
  - CHAR_ADDR+0, write: push `iowdt[7:0]` into the FIFO. If the FIFO is full, drop the byte and set `ovf`.
  - CHAR_ADDR+1, read: `{13'd0, ovf, fifo_full, busy}`. An `ior` pulse while `rdad`=CHAR_ADDR+1 clears `ovf` on the next edge. A simultaneous new overflow wins.
  - CHAR_ADDR+1, write: bit 1 set starts a clear-screen; the request is queued as FF (0x0C).
  - CHAR_ADDR+2, read: `{3'd0, y[4:0], 2'd0, x[5:0]}`.
  - CHAR_ADDR+2, write: set cursor from the same field layout. x ≥ COLS clamps to COLS-1; y ≥ ROWS clamps to ROWS-1. This write takes effect only when FSM=IDLE and the FIFO is empty; otherwise it is ignored.
  - Any other `rdad`: `iordt`=0. Writes to other addresses are ignored.
- FIFO:
  - Push and pop in the same cycle are legal while full: the pop frees the slot and the push is accepted.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM, IDLE: when the FIFO is not empty, pop a character `c` and decode it. Decode completes in the pop cycle.
  - 0x20–0x7E:
    - `tb_we`=1 for one cycle, `tb_addr`=y*COLS+x, `tb_wdata`=c.
    - Then x+1. If x reaches COLS, set x=0 and perform LF.
    - Latency: 1 cycle pop→write, registered outputs.
  - 0x0D (CR): x=0.
  - 0x0A (LF): if y<ROWS-1, y+1; otherwise go to SCROLL.
  - 0x08 (BS):
    - If x>0: x-1, then write 0x20 at the new position.
    - If x=0: no-op. No wrap to the previous row.
  - 0x0C (FF): go to CLEAR, then x=y=0.
  - All other codes are ignored, 1 cycle.
- SCROLL:
  - For a = 0 .. COLS*(ROWS-1)-1: read `tb_addr`=a+COLS, then on the next cycle write `tb_addr`=a with `tb_wdata`=`tb_rdata`. This is 2 cycles per cell.
  - Then write 0x20 to the last row, 1 cycle per cell.
  - Then return to IDLE with y=ROWS-1 and x unchanged.
  - Total 2*COLS*(ROWS-1)+COLS cycles.
- CLEAR: write 0x20 to addresses 0 .. COLS*ROWS-1, 1 per cycle, then return to IDLE.
- While in SCROLL or CLEAR, the FIFO still accepts pushes. Pops resume only in IDLE.
- `busy` is combinational from FSM state and FIFO occupancy.

Optional Feature:
- Macro: CONSOLE_TAB_EN.
- Defined: 0x09 (TAB) sets x to the next multiple of 8; no buffer writes.
  - If the result is ≥ COLS: x=0 and perform LF, which may scroll.
- Undefined: 0x09 is ignored like any other non-printable code.

Test Plan:
- Reset, then write 'A' (0x41) and 'B' (0x42) to 0x12 on consecutive cycles → `tb_we` pulses at addresses 0 and 1 with data 0x41 and 0x42. Cursor read at 0x14 = 0x0002.
- Set cursor {y=2, x=5}, send BS → writes 0x20 at address 84; cursor = {2,4}. Set x=0, send BS → no write; cursor unchanged.
- Send 40 printables from row 24 → the 40th char lands at address 999, then a scroll runs. `busy` stays high for 1960 cycles. Old row 1 now appears at row 0, row 24 is all 0x20, and the cursor = {24,0}.
- Send 6 chars in back-to-back `iow` cycles while busy (depth 4) → accepted chars render in order; status bit 2 (`ovf`)=1. A read of 0x13 with `ior` clears `ovf`.
- Send FF → 1000 writes of 0x20 at addresses 0–999; cursor {0,0}. Assert RESET at write #300 → `tb_we` drops on the next edge, cursor 0, FIFO empty.
- With CONSOLE_TAB_EN: at x=3 send TAB → x=8. At x=37 send TAB → x=0 and y+1.
